// File: rtl/lvds_pkg.sv
// Shared LVDS link definitions: comma/SOF code words, DATA tag and deframer states.
// The word aligner uses the same comma constants, so they live here.
package lvds_pkg;

    localparam logic [9:0] COMMA1   = 10'b01_0111_1100;
    localparam logic [9:0] COMMA2   = 10'b10_1000_0011;
    localparam logic [9:0] SOF_WORD = 10'b11_1111_0000;
    localparam logic [1:0] DATA_TAG = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAY,
        ST_CHK
    } deframe_state_t;

    function automatic logic is_data_word(input logic [9:0] word);
        return word[9:8] == DATA_TAG;
    endfunction

endpackage

// File: rtl/lvds_rx_deframer.sv
// Extracts SOF/LEN/payload/CHK frames from the aligned 10-bit word stream,
// streams payload bytes and reports per-frame checksum status plus statistics.
module lvds_rx_deframer
    import lvds_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             rx_clk,
    input  logic             rst,
    input  logic             align_done,
    input  logic [9:0]       rx_data,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [7:0]       frame_err_cnt
);

    deframe_state_t state;
    logic [7:0]     byte_cnt;
    logic           first_byte;
    logic [7:0]     xor_acc;
    logic           word_is_data;
    logic           word_is_sof;

    assign word_is_data = is_data_word(rx_data);
    assign word_is_sof  = (rx_data == SOF_WORD);

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            byte_cnt   <= '0;
            first_byte <= 1'b0;
            xor_acc    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (!align_done) begin
                // Losing alignment mid-frame kills the frame; in IDLE it is silent.
                state <= ST_IDLE;
                if (state != ST_IDLE) frame_err <= 1'b1;
            end else if (state != ST_IDLE && !word_is_data) begin
                // Abort, then treat the offending word as if seen in IDLE.
                frame_err <= 1'b1;
                if (word_is_sof) begin
                    state   <= ST_LEN;
                    xor_acc <= '0;
                end else begin
                    state <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (word_is_sof) begin
                            state   <= ST_LEN;
                            xor_acc <= '0;
                        end
                    end
                    ST_LEN: begin
                        if (rx_data[7:0] == 8'd0) begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            byte_cnt   <= rx_data[7:0];
                            first_byte <= 1'b1;
                            state      <= ST_PAY;
                        end
                    end
                    ST_PAY: begin
                        out_valid  <= 1'b1;
                        out_data   <= rx_data[7:0];
                        out_sof    <= first_byte;
                        out_eof    <= (byte_cnt == 8'd1);
                        first_byte <= 1'b0;
                        xor_acc    <= xor_acc ^ rx_data[7:0];
                        byte_cnt   <= byte_cnt - 8'd1;
                        if (byte_cnt == 8'd1) state <= ST_CHK;
                    end
                    ST_CHK: begin
                        if (rx_data[7:0] == xor_acc) frame_ok  <= 1'b1;
                        else                         frame_err <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Statistics follow the registered pulses, so they settle one cycle after them.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            frame_ok_cnt  <= '0;
            frame_err_cnt <= '0;
        end else begin
            if (frame_ok) frame_ok_cnt <= frame_ok_cnt + CNT_W'(1);
            if (frame_err && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Scoreboard bench for lvds_rx_deframer: frames are built from known parts, and each
// expected byte/pulse is queued as it is sent; a monitor pops and compares.
`timescale 1ns/1ps
module tb_lvds_rx_deframer;
    import lvds_pkg::*;

    logic        rx_clk = 1'b0;
    logic        rst;
    logic        align_done;
    logic [9:0]  rx_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] frame_ok_cnt;
    logic [7:0]  frame_err_cnt;

    lvds_rx_deframer #(.CNT_W(16)) dut (
        .rx_clk        (rx_clk),
        .rst           (rst),
        .align_done    (align_done),
        .rx_data       (rx_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_sof       (out_sof),
        .out_eof       (out_eof),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct {
        bit         is_byte;
        bit         is_ok;
        bit         is_err;
        logic [7:0] data;
        bit         sof;
        bit         eof;
    } exp_ev_t;

    exp_ev_t    exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         model_ok = 0;
    int         model_err = 0;
    logic [7:0] pl[256];
    bit         need_nondata = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] word, input logic al);
        @(posedge rx_clk);
        #1;
        rx_data    = word;
        align_done = al;
    endtask

    function automatic void push_ev(bit b, bit ok, bit err, logic [7:0] d, bit s, bit e);
        exp_ev_t ev;
        ev.is_byte = b;
        ev.is_ok   = ok;
        ev.is_err  = err;
        ev.data    = d;
        ev.sof     = s;
        ev.eof     = e;
        exp_q.push_back(ev);
    endfunction

    function automatic void expect_ok();
        push_ev(0, 1, 0, 8'h00, 0, 0);
        model_ok = (model_ok + 1) & 32'hFFFF;
    endfunction

    function automatic void expect_err();
        push_ev(0, 0, 1, 8'h00, 0, 0);
        model_err = (model_err == 255) ? 255 : model_err + 1;
    endfunction

    // Sends the first cnt bytes of an n-byte payload; x is their XOR.
    task automatic send_payload(input int n, input int cnt, output logic [7:0] x);
        x = 8'h00;
        for (int i = 0; i < cnt; i++) begin
            push_ev(1, 0, 0, pl[i], i == 0, i == n - 1);
            applyStimulus({DATA_TAG, pl[i]}, 1'b1);
            x = x ^ pl[i];
        end
    endtask

    task automatic send_sof_len(input int n);
        applyStimulus(SOF_WORD, 1'b1);
        need_nondata = 0;
        applyStimulus({DATA_TAG, 8'(n)}, 1'b1);
    endtask

    task automatic drain_and_check_counts(input string tag);
        int waited;
        if (need_nondata) begin
            applyStimulus(COMMA1, 1'b1);
            need_nondata = 0;
        end
        waited = 0;
        while (exp_q.size() != 0 && waited < 30) begin
            applyStimulus(COMMA2, 1'b1);
            waited++;
        end
        applyStimulus(COMMA2, 1'b1);
        applyStimulus(COMMA1, 1'b1);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_missing_outputs actual=%0d pending required=0 pending", tag, exp_q.size());
            exp_q.delete();
        end
        checkOutput({tag, "_frame_ok_cnt"}, frame_ok_cnt, model_ok);
        checkOutput({tag, "_frame_err_cnt"}, frame_err_cnt, model_err);
    endtask

    task automatic random_segment();
        int         kind;
        int         n;
        int         k;
        int         m;
        logic [7:0] x;
        logic [7:0] chk;
        kind = $urandom_range(0, 5);
        n = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 255)) : int'($urandom_range(1, 6));
        for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
        case (kind)
            0, 1: begin
                send_sof_len(n);
                send_payload(n, n, x);
                if (kind == 0) begin
                    chk = x;
                    expect_ok();
                end else begin
                    chk = x ^ (8'h01 << $urandom_range(0, 7));
                    expect_err();
                end
                applyStimulus({DATA_TAG, chk}, 1'b1);
            end
            2: begin
                send_sof_len(0);
                expect_err();
            end
            3, 4: begin
                if ($urandom_range(0, 3) == 0) begin
                    applyStimulus(SOF_WORD, 1'b1);
                end else begin
                    send_sof_len(n);
                    k = $urandom_range(0, n);
                    send_payload(n, k, x);
                end
                expect_err();
                if (kind == 3) begin
                    need_nondata = 1;
                end else begin
                    need_nondata = 0;
                    m = $urandom_range(1, 4);
                    for (int i = 0; i < m; i++) applyStimulus(10'($urandom), 1'b0);
                end
            end
            default: begin
                if (need_nondata) begin
                    applyStimulus(COMMA1, 1'b1);
                    need_nondata = 0;
                end
                m = $urandom_range(1, 4);
                for (int i = 0; i < m; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        applyStimulus(10'($urandom), 1'b0);
                    end else begin
                        case ($urandom_range(0, 3))
                            0:       applyStimulus(COMMA1, 1'b1);
                            1:       applyStimulus(COMMA2, 1'b1);
                            2:       applyStimulus({DATA_TAG, 8'($urandom)}, 1'b1);
                            default: applyStimulus(10'h3FF, 1'b1);
                        endcase
                    end
                end
            end
        endcase
    endtask

    // Every visible output event must match the head of the expectation queue.
    always @(negedge rx_clk) begin
        exp_ev_t e;
        if (out_valid || frame_ok || frame_err) begin
            checkOutput("ok_err_exclusive", frame_ok & frame_err, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output actual valid=%b ok=%b err=%b data=0x%02h required no output",
                         out_valid, frame_ok, frame_err, out_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_valid", out_valid, e.is_byte);
                checkOutput("frame_ok", frame_ok, e.is_ok);
                checkOutput("frame_err", frame_err, e.is_err);
                if (e.is_byte) begin
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("out_sof", out_sof, e.sof);
                    checkOutput("out_eof", out_eof, e.eof);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] x;
        rst        = 1'b1;
        align_done = 1'b0;
        rx_data    = 10'h000;
        repeat (3) @(posedge rx_clk);
        @(negedge rx_clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_frame_ok", frame_ok, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_ok_cnt", frame_ok_cnt, 0);
        checkOutput("reset_err_cnt", frame_err_cnt, 0);
        @(posedge rx_clk);
        #1;
        rst = 1'b0;

        // Reference frame: A1 ^ B2 ^ C3 = D0.
        pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
        applyStimulus(COMMA1, 1'b1);
        send_sof_len(3);
        send_payload(3, 3, x);
        expect_ok();
        applyStimulus(10'h0D0, 1'b1);
        drain_and_check_counts("good_frame");

        send_sof_len(3);
        send_payload(3, 3, x);
        expect_err();
        applyStimulus(10'h0D1, 1'b1);
        drain_and_check_counts("bad_chk");

        pl[0] = 8'h11;
        send_sof_len(2);
        send_payload(2, 1, x);
        expect_err();
        pl[0] = 8'h55;
        send_sof_len(1);
        send_payload(1, 1, x);
        expect_ok();
        applyStimulus(10'h055, 1'b1);
        drain_and_check_counts("sof_abort");

        pl[0] = 8'h12; pl[1] = 8'h34;
        send_sof_len(4);
        send_payload(4, 2, x);
        expect_err();
        applyStimulus({DATA_TAG, 8'h56}, 1'b0);
        applyStimulus(COMMA1, 1'b0);
        applyStimulus(COMMA2, 1'b0);
        applyStimulus(SOF_WORD, 1'b0);
        applyStimulus(COMMA1, 1'b1);
        applyStimulus(COMMA2, 1'b1);
        drain_and_check_counts("align_drop");

        for (int i = 0; i < 256; i++) begin
            send_sof_len(0);
            expect_err();
        end
        drain_and_check_counts("err_saturate");

        // Reset mid-payload: bytes already out stay out, no error pulse follows.
        pl[0] = 8'h9A; pl[1] = 8'hBC;
        send_sof_len(4);
        send_payload(4, 2, x);
        @(posedge rx_clk);
        #1;
        rst     = 1'b1;
        rx_data = {DATA_TAG, 8'hDE};
        @(posedge rx_clk);
        @(negedge rx_clk);
        checkOutput("rst_mid_out_valid", out_valid, 0);
        checkOutput("rst_mid_out_sof", out_sof, 0);
        checkOutput("rst_mid_frame_err", frame_err, 0);
        checkOutput("rst_mid_ok_cnt", frame_ok_cnt, 0);
        checkOutput("rst_mid_err_cnt", frame_err_cnt, 0);
        exp_q.delete();
        model_ok  = 0;
        model_err = 0;
        @(posedge rx_clk);
        #1;
        rst = 1'b0;
        pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
        send_sof_len(3);
        send_payload(3, 3, x);
        expect_ok();
        applyStimulus(10'h0D0, 1'b1);
        drain_and_check_counts("post_reset");

        for (int s = 0; s < 300; s++) random_segment();
        drain_and_check_counts("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lvds_rx_deframer.md
LVDS_RX_DEFRAMER -- requirements
Module: lvds_rx_deframer

Interface
REQ-001 Parameter: CNT_W, default 16, width of frame_ok_cnt.
REQ-002 rx_clk  input  1  word clock shared with the aligner; all logic on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 align_done  input  1  word alignment achieved; deframer enabled only while high.
REQ-005 rx_data  input  10  aligned received word, one per rx_clk.
REQ-006 out_data  output  8  payload byte.
REQ-007 out_valid  output  1  out_data valid this cycle.
REQ-008 out_sof / out_eof  output  1 each  first / last payload byte of a frame, qualified by out_valid.
REQ-009 frame_ok  output  1  one-cycle pulse: frame complete, checksum matched.
REQ-010 frame_err  output  1  one-cycle pulse: frame aborted or checksum mismatch.
REQ-011 frame_ok_cnt  output  CNT_W  count of good frames, wraps.
REQ-012 frame_err_cnt  output  8  count of bad frames, saturates at 255.

Function
REQ-013 Word classes: COMMA1 = 10'b01_0111_1100; COMMA2 = 10'b10_1000_0011; SOF = 10'b11_1111_0000; DATA = any word with [9:8] = 2'b00, value [7:0].
REQ-014 Frame format: SOF, LEN (DATA, N = [7:0], N = 1..255), then N DATA payload words, then CHK (DATA, XOR of all N payload bytes).
REQ-015 States: IDLE, LEN, PAY, CHK.
REQ-016 Transitions:
  - IDLE -> LEN on SOF.
  - LEN -> PAY on DATA with N != 0; byte counter loads N.
  - PAY -> CHK after the Nth payload word.
  - CHK -> IDLE on any word.
REQ-017 In IDLE, commas and all other non-SOF words are ignored with no output.
REQ-018 In LEN, a DATA word with N = 0 shall pulse frame_err and return to IDLE.
REQ-019 In LEN/PAY/CHK, a non-DATA word shall abort the frame:
  - frame_err pulses.
  - The word is then evaluated as if in IDLE, so SOF goes directly to LEN.
REQ-020 Each payload word shall produce out_valid with out_data = [7:0], registered, 1-cycle latency; out_sof on byte 1, out_eof on byte N; both asserted together when N = 1.
REQ-021 At the CHK word, registered 1 cycle later:
  - frame_ok pulses if [7:0] equals the running XOR, else frame_err.
  - Never both in the same cycle.
REQ-022 The running XOR clears on SOF and accumulates each payload byte.
REQ-023 frame_ok_cnt increments on each frame_ok (wraps from all-ones to 0); frame_err_cnt increments on each frame_err, holding at 255.
REQ-024 align_done low:
  - State is forced to IDLE; out_valid, out_sof and out_eof are held low.
  - Incoming words are ignored.
  - If align_done falls while in LEN/PAY/CHK, frame_err pulses once the following cycle.
REQ-025 Already-emitted bytes are not retracted on abort; consumers use frame_ok/frame_err to accept or discard the frame.

Reset
REQ-026 On rst high at a clock edge:
  - State = IDLE.
  - All outputs and counters = 0; XOR accumulator = 0.
  - rst overrides all other inputs, including mid-frame; no frame_err is generated by reset.

Structure
REQ-027 A shared package lvds_pkg holds COMMA1, COMMA2, SOF_WORD, the DATA tag 2'b00 and the state enumeration; the aligner uses the same comma constants from it.
REQ-028 Single flat module; no sub-module. The state machine, byte counter, XOR accumulator and statistics counters are inline.

Verification
REQ-029 align_done=1, words COMMA1, SOF, 0x003, 0x0A1, 0x0B2, 0x0C3, CHK 0x0D0 -> out_data A1/B2/C3 with sof on A1, eof on C3, frame_ok 1 cycle after CHK, frame_ok_cnt=1.
REQ-030 Same frame with CHK 0x0D1 -> three bytes emitted, frame_err pulse, frame_err_cnt=1, frame_ok_cnt=0.
REQ-031 SOF, LEN 0x002, 0x011, then SOF, LEN 0x001, 0x055, CHK 0x055 -> frame_err on the second SOF, then a single-byte frame with sof=eof=1 and frame_ok.
REQ-032 SOF, LEN 0x004, two payload words, then align_done drops -> frame_err one cycle later, no further out_valid, later COMMA words produce nothing.
REQ-033 LEN 0x000 after SOF -> frame_err, state IDLE; 256 consecutive bad frames -> frame_err_cnt = 255.
REQ-034 rst asserted during PAY -> next cycle all outputs 0 and IDLE; a following good frame decodes normally.
